// File: rtl/updown_seq_pkg.sv
// Shared types and widths for the up/down sequencer and its tick prescaler.
package updown_seq_pkg;

  localparam int PRESC_W = 25;
  localparam int CNT_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DWELL_TOP,
    DOWN,
    DWELL_BOT,
    DONE
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 divider producing a one-cycle tick on the wrap edge;
// clr forces the count to zero and en freezes it.
module tick_prescaler
  import updown_seq_pkg::*;
#(
  parameter int DIV = 25000000
) (
  input  logic c,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge c or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/updown_sequencer.sv
// Sequences out between latched lo/hi for CYCLES round trips with DWELL-tick pauses.
// Optional UDSEQ_SINGLE_STEP_EN adds a step input that issues one tick per rising edge while hold=1.
module updown_sequencer
  import updown_seq_pkg::*;
#(
  parameter int DIV    = 25000000,
  parameter int DWELL  = 2,
  parameter int CYCLES = 3
) (
  input  logic             c,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
`ifdef UDSEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [CNT_W-1:0] lo,
  input  logic [CNT_W-1:0] hi,
  output logic [CNT_W-1:0] out,
  output logic             clk_out,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   out_q, out_d, lo_q, lo_d, hi_q, hi_d;
  logic [3:0]         dwell_q, dwell_d, round_q, round_d;
  logic               clk_q, clk_d, dir_q, dir_d, busy_q, busy_d;
  logic               done_q, done_d, err_q, err_d;
  logic               presc_tick, tick, advance;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .c    (c),
    .reset(reset),
    .clr  (state_q == IDLE),
    .en   (!hold),
    .tick (presc_tick)
  );

`ifdef UDSEQ_SINGLE_STEP_EN
  logic step_q;
  logic step_pulse;

  assign step_pulse = step & ~step_q;
  assign tick       = presc_tick | (hold & step_pulse);
  assign advance    = !hold || step_pulse;

  always_ff @(posedge c or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end
`else
  assign tick    = presc_tick;
  assign advance = !hold;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dwell_d = dwell_q;
    round_d = round_q;
    err_d   = err_q;
    // stop wins over hold and start; hold freezes everything unless a step tick arrives
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
    end else if (advance) begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            if (lo < hi) begin
              lo_d    = lo;
              hi_d    = hi;
              out_d   = lo;
              dwell_d = '0;
              round_d = '0;
              err_d   = 1'b0;
              state_d = UP;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        UP: begin
          if (tick) begin
            out_d = out_q + 1'b1;
            if (out_d == hi_q) begin
              dwell_d = '0;
              state_d = DWELL_TOP;
            end
          end
        end
        DWELL_TOP, DWELL_BOT: begin
          if (tick) begin
            if (dwell_q + 4'd1 == 4'(DWELL)) state_d = (state_q == DWELL_TOP) ? DOWN : UP;
            else                             dwell_d = dwell_q + 4'd1;
          end
        end
        DOWN: begin
          if (tick) begin
            out_d = out_q - 1'b1;
            if (out_d == lo_q) begin
              round_d = round_q + 4'd1;
              dwell_d = '0;
              state_d = (round_d == 4'(CYCLES)) ? DONE : DWELL_BOT;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    clk_d  = clk_q ^ tick;
    dir_d  = (state_d == UP) ? 1'b1 : (state_d == DOWN) ? 1'b0 : dir_q;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge c or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      dwell_q <= '0;
      round_q <= '0;
      clk_q   <= 1'b0;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dwell_q <= dwell_d;
      round_q <= round_d;
      clk_q   <= clk_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out     = out_q;
  assign clk_out = clk_q;
  assign dir     = dir_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
